// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. In-order word requests to imem,
//               response buffering with PCs, valid/ready hand-off to decode,
//               and branch-redirect squashing of wrong-path traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_pc_branch,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr,
  input  logic            i_if_ready
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  iq_cnt_q, iq_cnt_d;
  logic [PTR_W-1:0]  pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
  logic [PTR_W-1:0]  iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;

  logic [XLEN-1:0]   pf_mem_q   [DEPTH];
  logic [XLEN-1:0]   iq_pc_q    [DEPTH];
  logic [31:0]       iq_instr_q [DEPTH];

  logic [CNT_W:0]    credit_used;
  logic [XLEN-1:0]   target;
  logic              req, fire, resp, push, pop, if_valid, iq_nonempty;

  assign target = i_pc_branch & ~XLEN'(3);

  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, iq_cnt_q};
    iq_nonempty = (iq_cnt_q != '0);
    req         = (state_q == RUN) && (credit_used < CREDITS) && !i_branch_taken;
    fire        = req && i_imem_gnt;
    // A response with nothing outstanding is a leftover from before reset.
    resp        = i_imem_rvalid && (outst_q != '0);
    push        = resp && (drop_q == '0) && !i_branch_taken;
    if_valid    = iq_nonempty && !i_branch_taken;
    pop         = if_valid && i_if_ready;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    iq_cnt_d = iq_cnt_q;
    pf_rd_d  = pf_rd_q;
    pf_wr_d  = pf_wr_q;
    iq_rd_d  = iq_rd_q;
    iq_wr_d  = iq_wr_q;

    if (state_q == BOOT) begin
      state_d = RUN;
    end

    if (fire) begin
      pc_d    = pc_q + XLEN'(4);
      pf_wr_d = pf_wr_q + PTR_W'(1);
    end
    if (resp) begin
      pf_rd_d = pf_rd_q + PTR_W'(1);
    end

    case ({fire, resp})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (push) begin
      iq_wr_d = iq_wr_q + PTR_W'(1);
    end
    if (pop) begin
      iq_rd_d = iq_rd_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   iq_cnt_d = iq_cnt_q + CNT_W'(1);
      2'b01:   iq_cnt_d = iq_cnt_q - CNT_W'(1);
      default: iq_cnt_d = iq_cnt_q;
    endcase

    // Every request still in flight after this edge belongs to the wrong path.
    if (i_branch_taken) begin
      pc_d     = target;
      drop_d   = outst_d;
      iq_rd_d  = '0;
      iq_wr_d  = '0;
      iq_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      iq_cnt_q <= '0;
      pf_rd_q  <= '0;
      pf_wr_q  <= '0;
      iq_rd_q  <= '0;
      iq_wr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      iq_cnt_q <= iq_cnt_d;
      pf_rd_q  <= pf_rd_d;
      pf_wr_q  <= pf_wr_d;
      iq_rd_q  <= iq_rd_d;
      iq_wr_q  <= iq_wr_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge i_clk) begin
    if (fire) begin
      pf_mem_q[pf_wr_q] <= pc_q;
    end
    if (push) begin
      iq_pc_q[iq_wr_q]    <= pf_mem_q[pf_rd_q];
      iq_instr_q[iq_wr_q] <= i_imem_rdata;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = if_valid;
  assign o_if_pc     = iq_nonempty ? iq_pc_q[iq_rd_q]    : '0;
  assign o_if_instr  = iq_nonempty ? iq_instr_q[iq_rd_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized self-checking bench for fetch_unit with a
//               queue-based reference model and an in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_branch_taken (br),
    .i_pc_branch    (br_tgt),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_gnt     (gnt),
    .i_imem_rvalid  (rvalid),
    .i_imem_rdata   (rdata),
    .o_if_valid     (if_valid),
    .o_if_pc        (if_pc),
    .o_if_instr     (if_instr),
    .i_if_ready     (ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory environment: in-order responses, one per cycle, latency in [lat_min, lat_max].
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          cyc      = 0;
  int          last_due = -1;
  int          lat_min  = 1;
  int          lat_max  = 1;

  // Reference model: fetch PC, in-flight request list, decode-side buffer.
  logic [31:0] m_pc  = RESET_PC;
  logic        m_run = 1'b0;
  logic [31:0] in_pc   [$];
  logic        in_live [$];
  logic [31:0] b_pc    [$];
  logic [31:0] b_instr [$];

  // Observations taken from the DUT for directed checks.
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  int          n_grants = 0;
  int          n_xfer   = 0;
  logic [31:0] last_grant_addr = '0;
  logic [31:0] last_xfer_pc    = '0;

  task automatic cycle();
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_instr;
    logic [31:0] p;
    logic        live;
    int          due;
    @(negedge clk);
    rvalid = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
    rdata  = rvalid ? mem_word(mq_addr[0]) : $urandom;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;

    e_req   = m_run && ((in_pc.size() + b_pc.size()) < DEPTH) && !br;
    e_valid = (b_pc.size() != 0) && !br;
    e_pc    = (b_pc.size() != 0) ? b_pc[0]    : 32'h0;
    e_instr = (b_pc.size() != 0) ? b_instr[0] : 32'h0;
    check_eq("imem_req",   {31'h0, s_req},   {31'h0, e_req});
    check_eq("imem_addr",  s_addr,           m_pc);
    check_eq("if_valid",   {31'h0, s_valid}, {31'h0, e_valid});
    check_eq("if_pc",      s_pc,             e_pc);
    check_eq("if_instr",   s_instr,          e_instr);

    if (s_valid && ready) begin
      n_xfer++;
      last_xfer_pc = s_pc;
    end

    // Memory environment reacts to what the DUT actually did.
    if (rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (s_req && gnt) begin
      n_grants++;
      last_grant_addr = s_addr;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(s_addr);
      mq_due.push_back(due);
    end

    // Reference model update for the coming edge.
    if (rst) begin
      m_pc  = RESET_PC;
      m_run = 1'b0;
      in_pc.delete();
      in_live.delete();
      b_pc.delete();
      b_instr.delete();
    end else begin
      if (rvalid && (in_pc.size() != 0)) begin
        p    = in_pc.pop_front();
        live = in_live.pop_front();
        if (live) begin
          b_pc.push_back(p);
          b_instr.push_back(rdata);
        end
      end
      if (e_valid && ready) begin
        void'(b_pc.pop_front());
        void'(b_instr.pop_front());
      end
      if (e_req && gnt) begin
        in_pc.push_back(m_pc);
        in_live.push_back(1'b1);
        m_pc = m_pc + 32'd4;
      end
      if (br) begin
        foreach (in_live[i]) in_live[i] = 1'b0;
        b_pc.delete();
        b_instr.delete();
        m_pc = {br_tgt[31:2], 2'b00};
      end
      m_run = 1'b1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds reset until the memory has drained so no stale response survives.
  task automatic do_reset();
    int k;
    rst   = 1'b1;
    br    = 1'b0;
    gnt   = 1'b0;
    ready = 1'b0;
    k = 0;
    while (((mq_addr.size() != 0) || (k < 2)) && (k < 50)) begin
      cycle();
      k++;
    end
    check_eq("reset_addr",  s_addr, RESET_PC);
    check_eq("reset_valid", {31'h0, s_valid}, 32'h0);
    check_eq("reset_pc",    s_pc, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_xfer(input string tag, input logic [31:0] exp_pc);
    int x0;
    int k;
    x0 = n_xfer;
    k  = 0;
    while ((n_xfer == x0) && (k < 40)) begin
      cycle();
      k++;
    end
    check_eq({tag, "_seen"}, {31'h0, (n_xfer != x0)}, 32'h1);
    check_eq({tag, "_pc"}, last_xfer_pc, exp_pc);
  endtask

  initial begin
    int g0;
    int x0;
    int k;

    // 1: straight-line fetch, first instruction three cycles after release.
    lat_min = 1; lat_max = 1;
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t1_valid_c3", {31'h0, s_valid}, 32'h1);
    check_eq("t1_pc_c3",    s_pc, RESET_PC);
    check_eq("t1_instr_c3", s_instr, mem_word(RESET_PC));
    for (int i = 0; i < 12; i++) cycle();

    // 2: decode stalled, credit limits issue to DEPTH requests.
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    g0 = n_grants;
    for (int i = 0; i < 12; i++) cycle();
    check_eq("t2_grants", n_grants - g0, DEPTH);
    check_eq("t2_hold_pc", s_pc, RESET_PC);
    check_eq("t2_hold_instr", s_instr, mem_word(RESET_PC));
    ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("t2_resume", {31'h0, (n_xfer - x0 >= 4)}, 32'h1);

    // 3: redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    br = 1'b1; br_tgt = 32'h0000_0100;
    cycle();
    br = 1'b0; ready = 1'b1;
    wait_xfer("t3_first", 32'h0000_0100);

    // 4: redirect coinciding with gnt and rvalid, unaligned target.
    lat_min = 1; lat_max = 1;
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    cycle();
    cycle();
    br = 1'b1; br_tgt = 32'h0000_0203;
    cycle();
    check_eq("t4_rvalid_here", {31'h0, rvalid}, 32'h1);
    check_eq("t4_req_low", {31'h0, s_req}, 32'h0);
    br = 1'b0;
    cycle();
    check_eq("t4_next_addr", s_addr, 32'h0000_0200);
    check_eq("t4_next_req", {31'h0, s_req}, 32'h1);
    wait_xfer("t4_first", 32'h0000_0200);

    // 5: PC wraps past the top of the address space.
    br = 1'b1; br_tgt = 32'hFFFF_FFFC;
    cycle();
    br = 1'b0;
    g0 = n_grants;
    k  = 0;
    while ((n_grants == g0) && (k < 20)) begin
      cycle();
      k++;
    end
    check_eq("t5_grant_addr", last_grant_addr, 32'hFFFF_FFFC);
    cycle();
    check_eq("t5_wrap_addr", s_addr, 32'h0000_0000);
    for (int i = 0; i < 8; i++) cycle();

    // 6: reset with two outstanding; their responses land after release.
    lat_min = 3; lat_max = 3;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check_eq("t6_late_rvalid", {31'h0, rvalid}, 32'h1);
    ready = 1'b1;
    wait_xfer("t6_first", RESET_PC);
    check_eq("t6_instr", s_instr, mem_word(RESET_PC));

    // Randomized traffic: variable latency, stalls, redirects, rare resets.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        do_reset();
      end
      gnt    = ($urandom_range(99, 0) < 70);
      ready  = ($urandom_range(99, 0) < 70);
      br     = ($urandom_range(99, 0) < 4);
      br_tgt = $urandom;
      cycle();
    end
    br = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
